// File: rtl/puf_ctrl_pkg.sv
// Shared types and defaults for the PUF challenge/response sequencer.
// No logic; no latency; no flow control.
package puf_ctrl_pkg;

    localparam int CHAL_W_DEF = 16;
    localparam int RESP_W_DEF = 32;
    localparam int CRP_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_SETTLE,
        ST_CAPTURE,
        ST_SEND,
        ST_WAIT_DONE
    } state_t;

endpackage

// File: rtl/b2g_converter.sv
// Binary to reflected-Gray encoder.
// Purely combinational, zero latency; no flow control.
module b2g_converter #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_bin,
    output logic [W-1:0] o_gray
);

    assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

// File: rtl/puf_crp_sequencer.sv
// Sequences one challenge/response through the PUF: RX -> Gray -> arm/settle -> capture -> TX. Optional PUF_ECHO_EN.
// Latency: rx_done rise to tx_start is SETTLE_CYC+5 cycles.
// Backpressure: holds in WAIT_DONE until a fresh tx_done rise; challenges arriving while busy are dropped.
module puf_crp_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int CHAL_W     = CHAL_W_DEF,
    parameter int RESP_W     = RESP_W_DEF,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_done,
    input  logic [CHAL_W-1:0]    rx_data,
`ifdef PUF_ECHO_EN
    input  logic                 echo_mode,
`endif
    output logic                 puf_arm,
    output logic [CHAL_W-1:0]    puf_challenge,
    input  logic [RESP_W-1:0]    puf_response,
    output logic                 tx_start,
    output logic [RESP_W-1:0]    tx_data,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 drop,
    output logic [CRP_CNT_W-1:0] crp_count
);

    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_t                r_state;
    state_t                w_next;
    logic                  r_rx_prev;
    logic                  r_tx_prev;
    logic [CHAL_W-1:0]     r_chal;
    logic [CHAL_W-1:0]     r_puf_chal;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_puf_arm;
    logic                  r_tx_start;
    logic [RESP_W-1:0]     r_tx_data;
    logic                  r_drop;
    logic [CRP_CNT_W-1:0]  r_crp_count;

    logic                  w_rx_rise;
    logic                  w_tx_rise;
    logic [CHAL_W-1:0]     w_gray;
    logic                  w_echo;
    logic                  w_arm_nxt;
    logic                  w_tx_start_nxt;
    logic                  w_drop_nxt;
    logic                  w_busy;

    assign w_rx_rise = rx_done & ~r_rx_prev;
    assign w_tx_rise = tx_done & ~r_tx_prev;

    b2g_converter #(.W(CHAL_W)) u_b2g (
        .i_bin  (r_chal),
        .o_gray (w_gray)
    );

`ifdef PUF_ECHO_EN
    logic r_echo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_echo <= 1'b0;
        end else if (r_state == ST_IDLE && w_rx_rise) begin
            r_echo <= echo_mode;
        end
    end

    assign w_echo = r_echo;
`else
    assign w_echo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_rx_rise) w_next = ST_LOAD;
            ST_LOAD:      w_next = ST_ARM;
            ST_ARM:       w_next = ST_SETTLE;
            ST_SETTLE:    if (r_cnt == '0) w_next = ST_CAPTURE;
            ST_CAPTURE:   w_next = ST_SEND;
            ST_SEND:      w_next = ST_WAIT_DONE;
            ST_WAIT_DONE: if (w_tx_rise) w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered, so each appears one cycle after its state.
    always_comb begin
        w_arm_nxt      = 1'b0;
        w_tx_start_nxt = 1'b0;
        w_drop_nxt     = 1'b0;
        w_busy         = (r_state != ST_IDLE);
        if ((r_state == ST_ARM || r_state == ST_SETTLE) && !w_echo) begin
            w_arm_nxt = 1'b1;
        end
        if (r_state == ST_SEND) begin
            w_tx_start_nxt = 1'b1;
        end
        if (w_rx_rise && r_state != ST_IDLE) begin
            w_drop_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_prev   <= 1'b0;
            r_tx_prev   <= 1'b0;
            r_chal      <= '0;
            r_puf_chal  <= '0;
            r_cnt       <= '0;
            r_puf_arm   <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_drop      <= 1'b0;
            r_crp_count <= '0;
        end else begin
            r_rx_prev  <= rx_done;
            r_tx_prev  <= tx_done;
            r_puf_arm  <= w_arm_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_drop     <= w_drop_nxt;
            case (r_state)
                ST_IDLE:      if (w_rx_rise) r_chal <= rx_data;
                ST_LOAD:      r_puf_chal <= w_gray;
                ST_ARM:       r_cnt <= CNT_W'(SETTLE_CYC - 1);
                ST_SETTLE:    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                ST_CAPTURE:   r_tx_data <= w_echo ? RESP_W'(r_chal) : puf_response;
                ST_WAIT_DONE: if (w_tx_rise) r_crp_count <= r_crp_count + 1'b1;
                default:      ;
            endcase
        end
    end

    assign puf_arm       = r_puf_arm;
    assign puf_challenge = r_puf_chal;
    assign tx_start      = r_tx_start;
    assign tx_data       = r_tx_data;
    assign busy          = w_busy;
    assign drop          = r_drop;
    assign crp_count     = r_crp_count;

endmodule

// File: tb/tb_puf_crp_sequencer.sv
// Directed bench for puf_crp_sequencer (SETTLE_CYC=8); echo scenario only when PUF_ECHO_EN is defined.
module tb_puf_crp_sequencer;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_done;
    logic [15:0] rx_data;
    logic        puf_arm;
    logic [15:0] puf_challenge;
    logic [31:0] puf_response;
    logic        tx_start;
    logic [31:0] tx_data;
    logic        tx_done;
    logic        busy;
    logic        drop;
    logic [15:0] crp_count;
`ifdef PUF_ECHO_EN
    logic        echo_mode;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    puf_crp_sequencer #(.CHAL_W(16), .RESP_W(32), .SETTLE_CYC(S)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_done       (rx_done),
        .rx_data       (rx_data),
`ifdef PUF_ECHO_EN
        .echo_mode     (echo_mode),
`endif
        .puf_arm       (puf_arm),
        .puf_challenge (puf_challenge),
        .puf_response  (puf_response),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_done       (tx_done),
        .busy          (busy),
        .drop          (drop),
        .crp_count     (crp_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; tick i observes outputs after the i-th edge since rx_done went high.
    task automatic do_txn(input logic [15:0] chal, input logic [31:0] resp, input bit inj,
                          input int done_delay, output int arm_cnt, output int ts_tick,
                          output int ts_cnt, output int drop_cnt, output logic [15:0] chal2,
                          output logic [15:0] chal_end, output logic [31:0] txd,
                          output logic [15:0] cnt_obs, output logic busy_obs);
        arm_cnt = 0; ts_tick = 0; ts_cnt = 0; drop_cnt = 0;
        chal2 = '0;
        rx_data = chal; puf_response = resp; rx_done = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (puf_arm) arm_cnt++;
            if (tx_start) begin ts_cnt++; if (ts_tick == 0) ts_tick = i; end
            if (drop) drop_cnt++;
            if (i == 2) begin chal2 = puf_challenge; rx_done = 1'b0; end
            if (inj && i == 4) begin rx_data = 16'h00FF; rx_done = 1'b1; end
            if (inj && i == 6) rx_done = 1'b0;
        end
        chal_end = puf_challenge;
        txd = tx_data;
        for (int d = 0; d < done_delay; d++) begin
            tick();
            if (tx_start) ts_cnt++;
            if (drop) drop_cnt++;
            if (puf_arm) arm_cnt++;
        end
        tx_done = 1'b1;
        tick();
        if (tx_start) ts_cnt++;
        cnt_obs = crp_count;
        busy_obs = busy;
        tx_done = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx_done = 1'b0; tx_done = 1'b0; rx_data = '0; puf_response = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++;
        if ({puf_arm, tx_start, busy, drop} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctl: got arm/start/busy/drop=%b want 0000", {puf_arm, tx_start, busy, drop});
        end
        total++;
        if (puf_challenge !== 16'h0000) begin bad++; $display("FAIL reset_chal: got %h want 0000", puf_challenge); end
        total++;
        if (tx_data !== 32'h0) begin bad++; $display("FAIL reset_txdata: got %h want 00000000", tx_data); end
        total++;
        if (crp_count !== 16'h0) begin bad++; $display("FAIL reset_cnt: got %h want 0000", crp_count); end
    endtask

    task automatic test_reset_mid();
        int starts;
        starts = 0;
        rx_data = 16'h000A; puf_response = 32'h12345678; rx_done = 1'b1;
        tick(); tick();
        rx_done = 1'b0;
        tick(); tick();
        total++;
        if (puf_arm !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_settle: got arm=%b busy=%b want 1 1", puf_arm, busy);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({puf_arm, tx_start, busy, drop} !== 4'b0000) begin
            bad++; $display("FAIL mid_rst_ctl: got arm/start/busy/drop=%b want 0000", {puf_arm, tx_start, busy, drop});
        end
        total++;
        if (puf_challenge !== 16'h0000 || tx_data !== 32'h0) begin
            bad++; $display("FAIL mid_rst_data: got chal=%h txd=%h want 0000 00000000", puf_challenge, tx_data);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx_start) starts++;
        end
        total++;
        if (starts !== 0) begin bad++; $display("FAIL mid_no_start: got %0d tx_start want 0", starts); end
        total++;
        if (crp_count !== 16'h0 || busy !== 1'b0) begin
            bad++; $display("FAIL mid_after: got cnt=%h busy=%b want 0000 0", crp_count, busy);
        end
    endtask

    task automatic test_single();
        int arm, tst, tsc, drp;
        logic [15:0] c2, ce, cnt;
        logic [31:0] txd;
        logic bz;
        do_txn(16'h0005, 32'hDEADBEEF, 1'b0, 19, arm, tst, tsc, drp, c2, ce, txd, cnt, bz);
        total++;
        if (c2 !== 16'h0007) begin bad++; $display("FAIL single_chal: got %h want 0007", c2); end
        total++;
        if (arm !== S + 1) begin bad++; $display("FAIL single_arm: got %0d cycles want %0d", arm, S + 1); end
        total++;
        if (tst !== S + 5) begin bad++; $display("FAIL single_latency: got %0d want %0d", tst, S + 5); end
        total++;
        if (tsc !== 1) begin bad++; $display("FAIL single_start_cnt: got %0d want 1", tsc); end
        total++;
        if (txd !== 32'hDEADBEEF) begin bad++; $display("FAIL single_txdata: got %h want deadbeef", txd); end
        total++;
        if (cnt !== 16'h0001 || bz !== 1'b0) begin
            bad++; $display("FAIL single_done: got cnt=%h busy=%b want 0001 0", cnt, bz);
        end
        total++;
        if (drp !== 0) begin bad++; $display("FAIL single_drop: got %0d want 0", drp); end
    endtask

    task automatic test_drop();
        int arm, tst, tsc, drp, extra;
        logic [15:0] c2, ce, cnt;
        logic [31:0] txd;
        logic bz;
        extra = 0;
        do_txn(16'h0005, 32'hCAFEF00D, 1'b1, 3, arm, tst, tsc, drp, c2, ce, txd, cnt, bz);
        total++;
        if (drp !== 1) begin bad++; $display("FAIL drop_pulse: got %0d want 1", drp); end
        total++;
        if (ce !== 16'h0007) begin bad++; $display("FAIL drop_chal: got %h want 0007", ce); end
        total++;
        if (tsc !== 1 || tst !== S + 5) begin
            bad++; $display("FAIL drop_start: got cnt=%0d tick=%0d want 1 %0d", tsc, tst, S + 5);
        end
        total++;
        if (txd !== 32'hCAFEF00D || cnt !== 16'h0002) begin
            bad++; $display("FAIL drop_result: got txd=%h cnt=%h want cafef00d 0002", txd, cnt);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (tx_start || busy) extra++;
        end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL drop_no_followup: got %0d busy/start cycles want 0", extra); end
    endtask

    task automatic test_stale();
        int tst;
        tst = 0;
        rx_data = 16'h0003; puf_response = 32'h0BADF00D; rx_done = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (tx_start && tst == 0) tst = i;
            if (i == 2) rx_done = 1'b0;
            if (i == 10) tx_done = 1'b1;
        end
        total++;
        if (tst !== S + 5 || puf_challenge !== 16'h0002) begin
            bad++; $display("FAIL stale_path: got tick=%0d chal=%h want %0d 0002", tst, puf_challenge, S + 5);
        end
        for (int i = 0; i < 5; i++) tick();
        total++;
        if (busy !== 1'b1 || crp_count !== 16'h0002) begin
            bad++; $display("FAIL stale_hold: got busy=%b cnt=%h want 1 0002", busy, crp_count);
        end
        tx_done = 1'b0;
        tick();
        tx_done = 1'b1;
        tick();
        total++;
        if (crp_count !== 16'h0003 || busy !== 1'b0) begin
            bad++; $display("FAIL stale_fresh: got cnt=%h busy=%b want 0003 0", crp_count, busy);
        end
        tick(); tick(); tick();
        total++;
        if (crp_count !== 16'h0003) begin bad++; $display("FAIL stale_once: got %h want 0003", crp_count); end
        tx_done = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        rx_data = 16'h0011; puf_response = 32'h11112222; rx_done = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 2) rx_done = 1'b0;
        end
        rx_data = 16'h0055; rx_done = 1'b1; tx_done = 1'b1;
        tick();
        total++;
        if (drop !== 1'b1 || busy !== 1'b0 || crp_count !== 16'h0004) begin
            bad++; $display("FAIL b2b_exit: got drop=%b busy=%b cnt=%h want 1 0 0004", drop, busy, crp_count);
        end
        tick();
        total++;
        if (busy !== 1'b0 || drop !== 1'b0) begin
            bad++; $display("FAIL b2b_idle: got busy=%b drop=%b want 0 0", busy, drop);
        end
        rx_done = 1'b0; tx_done = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int arm, tst, tsc, drp;
        logic [15:0] c2, ce, cnt;
        logic [31:0] txd;
        logic bz;
        force dut.r_crp_count = 16'hFFFE;
        #1;
        release dut.r_crp_count;
        do_txn(16'h0100, 32'h00000001, 1'b0, 2, arm, tst, tsc, drp, c2, ce, txd, cnt, bz);
        total++;
        if (cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_ffff: got %h want ffff", cnt); end
        do_txn(16'h0101, 32'h00000002, 1'b0, 2, arm, tst, tsc, drp, c2, ce, txd, cnt, bz);
        total++;
        if (cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", cnt); end
        total++;
        if (c2 !== 16'h0181) begin bad++; $display("FAIL wrap_chal: got %h want 0181", c2); end
    endtask

`ifdef PUF_ECHO_EN
    task automatic test_echo();
        int arm, tst, tsc, drp;
        logic [15:0] c2, ce, cnt;
        logic [31:0] txd;
        logic bz;
        echo_mode = 1'b1;
        do_txn(16'h1234, 32'h55AA55AA, 1'b0, 2, arm, tst, tsc, drp, c2, ce, txd, cnt, bz);
        echo_mode = 1'b0;
        total++;
        if (arm !== 0) begin bad++; $display("FAIL echo_arm: got %0d cycles want 0", arm); end
        total++;
        if (txd !== 32'h00001234) begin bad++; $display("FAIL echo_txdata: got %h want 00001234", txd); end
        total++;
        if (tst !== S + 5 || c2 !== 16'h1B2E) begin
            bad++; $display("FAIL echo_timing: got tick=%0d chal=%h want %0d 1b2e", tst, c2, S + 5);
        end
    endtask
`endif

    initial begin
`ifdef PUF_ECHO_EN
        echo_mode = 1'b0;
`endif
        test_reset();
        test_reset_mid();
        test_single();
        test_drop();
        test_stale();
        test_back_to_back();
        test_wrap();
`ifdef PUF_ECHO_EN
        test_echo();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
